cvbs_sync_gen: RTL and testbench

//  Generates a PAL 625-line interlaced composite video stream as a 6-bit level for the output DAC path.

---
 rtl/cvbs_sync_gen.sv | 167 ++++++++++++++++
 tb/tb_cvbs_sync_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cvbs_sync_gen.sv
// cvbs_sync_gen: PAL 625-line interlaced composite sync/level generator.
// Counts ce ticks and lines, inserts hsync, equalizing and broad pulses,
// and fills the active window with caller pixels over a programmable black.
// Optional build macro: CVBS_CLAMP_EN clamps active pixels to
// [black, min(black+32, 63)] so pixel data can never imitate a sync tip.
module cvbs_sync_gen #(
  parameter int unsigned LINE_TICKS       = 1536,
  parameter int unsigned HSYNC_TICKS      = 113,
  parameter int unsigned EQ_TICKS         = 56,
  parameter int unsigned BROAD_TICKS      = 655,
  parameter int unsigned BACKPORCH_TICKS  = 137,
  parameter int unsigned FRONTPORCH_TICKS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [5:0]  black,
  input  logic [5:0]  pix,
  output logic [5:0]  cvbs,
  output logic        sync_n,
  output logic        vsync,
  output logic        pix_req,
  output logic        field,
  output logic [9:0]  line,
  output logic [10:0] hpos
);

  localparam int unsigned HW = 11;
  localparam int unsigned LW = 10;
  localparam int unsigned VW = 6;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_TICKS - 1);
  localparam logic [HW-1:0] H_HALF    = HW'(LINE_TICKS / 2);
  localparam logic [HW-1:0] ACT_START = HW'(HSYNC_TICKS + BACKPORCH_TICKS);
  localparam logic [HW-1:0] ACT_END   = HW'(LINE_TICKS - FRONTPORCH_TICKS);
  localparam logic [HW-1:0] W_HSYNC   = HW'(HSYNC_TICKS);
  localparam logic [HW-1:0] W_EQ      = HW'(EQ_TICKS);
  localparam logic [HW-1:0] W_BROAD   = HW'(BROAD_TICKS);

  localparam logic [LW-1:0] LINE_FIRST = LW'(1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(625);
  localparam logic [LW-1:0] LINE_F0END = LW'(312);

  typedef enum logic [1:0] {
    HT_NONE  = 2'd0,
    HT_NORM  = 2'd1,
    HT_EQ    = 2'd2,
    HT_BROAD = 2'd3
  } half_t;

  half_t         h1_type_c;
  half_t         h2_type_c;
  half_t         cur_type_c;
  logic          second_half_c;
  logic [HW-1:0] off_c;
  logic          low_c;
  logic          vsync_c;
  logic          active_line_c;
  logic          win_c;
  logic [VW-1:0] level_c;

  // Half-line pulse types from the field line table
  always_comb begin
    h1_type_c = HT_NORM;
    h2_type_c = HT_NONE;
    if (line <= 10'd2) begin
      h1_type_c = HT_BROAD; h2_type_c = HT_BROAD;
    end else if (line == 10'd3) begin
      h1_type_c = HT_BROAD; h2_type_c = HT_EQ;
    end else if (line <= 10'd5) begin
      h1_type_c = HT_EQ;    h2_type_c = HT_EQ;
    end else if (line <= 10'd310) begin
      h1_type_c = HT_NORM;  h2_type_c = HT_NONE;
    end else if (line <= 10'd312) begin
      h1_type_c = HT_EQ;    h2_type_c = HT_EQ;
    end else if (line == 10'd313) begin
      h1_type_c = HT_EQ;    h2_type_c = HT_BROAD;
    end else if (line <= 10'd315) begin
      h1_type_c = HT_BROAD; h2_type_c = HT_BROAD;
    end else if (line <= 10'd317) begin
      h1_type_c = HT_EQ;    h2_type_c = HT_EQ;
    end else if (line == 10'd318) begin
      h1_type_c = HT_EQ;    h2_type_c = HT_NONE;
    end else if (line <= 10'd622) begin
      h1_type_c = HT_NORM;  h2_type_c = HT_NONE;
    end else if (line == 10'd623) begin
      h1_type_c = HT_NORM;  h2_type_c = HT_EQ;
    end else begin
      h1_type_c = HT_EQ;    h2_type_c = HT_EQ;
    end
  end

  // Pulse low decision relative to the start of the current half-line
  always_comb begin
    second_half_c = (hpos >= H_HALF);
    off_c         = second_half_c ? (hpos - H_HALF) : hpos;
    cur_type_c    = second_half_c ? h2_type_c : h1_type_c;
    low_c         = 1'b0;
    case (cur_type_c)
      HT_NORM:  low_c = (off_c < W_HSYNC);
      HT_EQ:    low_c = (off_c < W_EQ);
      HT_BROAD: low_c = (off_c < W_BROAD);
      default:  low_c = 1'b0;
    endcase
    vsync_c       = (cur_type_c == HT_BROAD);
    active_line_c = ((line >= 10'd23)  && (line <= 10'd310)) ||
                    ((line >= 10'd336) && (line <= 10'd622));
    win_c         = active_line_c && (hpos >= ACT_START) && (hpos < ACT_END);
  end

`ifdef CVBS_CLAMP_EN
  logic [6:0]    hi7_c;
  logic [VW-1:0] hi_c;
  logic [VW-1:0] lo_sel_c;

  // Active level kept between black and black+32 (saturated at full scale)
  always_comb begin
    hi7_c    = 7'({1'b0, black}) + 7'd32;
    hi_c     = hi7_c[6] ? 6'd63 : hi7_c[5:0];
    lo_sel_c = (pix < black) ? black : pix;
    level_c  = (lo_sel_c > hi_c) ? hi_c : lo_sel_c;
  end
`else
  // Active level passed through untouched
  assign level_c = pix;
`endif

  // Line/tick counters and field flag
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos  <= '0;
      line  <= LINE_FIRST;
      field <= 1'b0;
    end else if (ce) begin
      if (hpos == H_LAST) begin
        hpos <= '0;
        if (line == LINE_LAST) begin
          line  <= LINE_FIRST;
          field <= 1'b0;
        end else begin
          line <= line + LW'(1);
          if (line == LINE_F0END) field <= 1'b1;
        end
      end else begin
        hpos <= hpos + HW'(1);
      end
    end
  end

  // Registered video outputs, one ce behind the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cvbs    <= '0;
      sync_n  <= 1'b0;
      vsync   <= 1'b0;
      pix_req <= 1'b0;
    end else if (ce) begin
      sync_n  <= ~low_c;
      vsync   <= vsync_c;
      pix_req <= win_c;
      if (low_c)      cvbs <= '0;
      else if (win_c) cvbs <= level_c;
      else            cvbs <= black;
    end
  end

endmodule

// File: tb/tb_cvbs_sync_gen.sv
// tb_cvbs_sync_gen: directed checks of cvbs_sync_gen.
// Instance 0 uses default timing for line-level pulse shapes, pixels, hold and reset.
// Instance 1 uses a short line (64 ticks) so field wrap and a full frame fit in the run.
module tb_cvbs_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] black = 6'd12;

  logic        d_reset, d_ce;
  logic [5:0]  d_pix, d_cvbs;
  logic        d_sync_n, d_vsync, d_pix_req, d_field;
  logic [9:0]  d_line;
  logic [10:0] d_hpos;

  logic        s_reset, s_ce;
  logic [5:0]  s_pix, s_cvbs;
  logic        s_sync_n, s_vsync, s_pix_req, s_field;
  logic [9:0]  s_line;
  logic [10:0] s_hpos;

  cvbs_sync_gen u_dut (
    .clk(clk), .reset(d_reset), .ce(d_ce), .black(black), .pix(d_pix),
    .cvbs(d_cvbs), .sync_n(d_sync_n), .vsync(d_vsync), .pix_req(d_pix_req),
    .field(d_field), .line(d_line), .hpos(d_hpos)
  );

  cvbs_sync_gen #(
    .LINE_TICKS(64), .HSYNC_TICKS(5), .EQ_TICKS(2), .BROAD_TICKS(27),
    .BACKPORCH_TICKS(6), .FRONTPORCH_TICKS(2)
  ) u_small (
    .clk(clk), .reset(s_reset), .ce(s_ce), .black(black), .pix(s_pix),
    .cvbs(s_cvbs), .sync_n(s_sync_n), .vsync(s_vsync), .pix_req(s_pix_req),
    .field(s_field), .line(s_line), .hpos(s_hpos)
  );

  // Uniform view of both instances, indexed by instance select
  logic [5:0]  o_cvbs [2];
  logic        o_sync_n [2];
  logic        o_vsync [2];
  logic        o_pix_req [2];
  logic        o_field [2];
  logic [9:0]  o_line [2];
  logic [10:0] o_hpos [2];
  assign o_cvbs[0] = d_cvbs;       assign o_cvbs[1] = s_cvbs;
  assign o_sync_n[0] = d_sync_n;   assign o_sync_n[1] = s_sync_n;
  assign o_vsync[0] = d_vsync;     assign o_vsync[1] = s_vsync;
  assign o_pix_req[0] = d_pix_req; assign o_pix_req[1] = s_pix_req;
  assign o_field[0] = d_field;     assign o_field[1] = s_field;
  assign o_line[0] = d_line;       assign o_line[1] = s_line;
  assign o_hpos[0] = d_hpos;       assign o_hpos[1] = s_hpos;

  // Reference counters: m* = state, p* = position the outputs describe
  int ml [2];
  int mh [2];
  int pl [2];
  int ph [2];
  int ns [2];
  int lt [2] = '{1536, 64};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int sel);
    logic r, c;
    @(posedge clk);
    r = (sel == 0) ? d_reset : s_reset;
    c = (sel == 0) ? d_ce : s_ce;
    #1;
    if (r) begin
      ml[sel] = 1; mh[sel] = 0; ns[sel] = 0;
    end else if (c) begin
      pl[sel] = ml[sel]; ph[sel] = mh[sel]; ns[sel]++;
      if (mh[sel] == lt[sel] - 1) begin
        mh[sel] = 0;
        ml[sel] = (ml[sel] == 625) ? 1 : ml[sel] + 1;
      end else begin
        mh[sel]++;
      end
    end
  endtask

  task automatic advance(input int sel, input int ln, input int h, input string tag);
    for (int i = 0; i < 100000 && !(ml[sel] == ln && mh[sel] == h); i++) step(sel);
    check({tag, " reach line"}, int'(o_line[sel]), ln);
    check({tag, " reach hpos"}, int'(o_hpos[sel]), h);
  endtask

  function automatic bit in_rng(input int x, input int a, input int b);
    return (a >= 0) && (x >= a) && (x <= b);
  endfunction

  // Walk one full line; low intervals [a0,a1],[b0,b1]; window [wlo,whi] (wlo<0: none)
  task automatic scan(input int sel, input string tag, input int ln,
                      input int a0, input int a1, input int b0, input int b1,
                      input int vs1, input int vs2, input int wlo, input int whi,
                      input int pe);
    int bad_sync, bad_vs, bad_cv, bad_pr, bad_pos, first_pr, last_pr;
    bit low, act;
    int ecv, evs;
    bad_sync = 0; bad_vs = 0; bad_cv = 0; bad_pr = 0; bad_pos = 0;
    first_pr = -1; last_pr = -1;
    advance(sel, ln, 0, tag);
    for (int i = 0; i < lt[sel]; i++) begin
      step(sel);
      low = in_rng(ph[sel], a0, a1) || in_rng(ph[sel], b0, b1);
      act = (wlo >= 0) && (ph[sel] >= wlo) && (ph[sel] <= whi);
      ecv = low ? 0 : (act ? pe : 12);
      evs = (ph[sel] < lt[sel] / 2) ? vs1 : vs2;
      if (o_sync_n[sel] !== !low) bad_sync++;
      if (int'(o_vsync[sel]) != evs) bad_vs++;
      if (int'(o_cvbs[sel]) != ecv) bad_cv++;
      if (o_pix_req[sel] !== act) bad_pr++;
      if (int'(o_line[sel]) != ml[sel] || int'(o_hpos[sel]) != mh[sel] ||
          o_field[sel] !== (ml[sel] >= 313)) bad_pos++;
      if (o_pix_req[sel] === 1'b1) begin
        if (first_pr < 0) first_pr = ph[sel];
        last_pr = ph[sel];
      end
    end
    check({tag, " sync_n bad ticks"}, bad_sync, 0);
    check({tag, " vsync bad ticks"}, bad_vs, 0);
    check({tag, " cvbs bad ticks"}, bad_cv, 0);
    check({tag, " pix_req bad ticks"}, bad_pr, 0);
    check({tag, " counter bad ticks"}, bad_pos, 0);
    if (wlo >= 0) begin
      check({tag, " first pix_req hpos"}, first_pr, wlo);
      check({tag, " last pix_req hpos"}, last_pr, whi);
    end
  endtask

  task automatic default_flow();
    int bad_hold;
    bit low;
    int pe_hi, pe_lo;
`ifdef CVBS_CLAMP_EN
    pe_hi = 44; pe_lo = 12;
`else
    pe_hi = 50; pe_lo = 5;
`endif
    d_reset = 1'b1; d_ce = 1'b1; d_pix = 6'd0;
    repeat (3) step(0);
    check("rst hpos", int'(d_hpos), 0);
    check("rst line", int'(d_line), 1);
    check("rst field", int'(d_field), 0);
    check("rst cvbs", int'(d_cvbs), 0);
    check("rst sync_n", int'(d_sync_n), 0);
    check("rst vsync", int'(d_vsync), 0);
    check("rst pix_req", int'(d_pix_req), 0);
    d_reset = 1'b0;

    scan(0, "L1", 1, 0, 654, 768, 1422, 1, 1, -1, -1, 0);
    scan(0, "L3", 3, 0, 654, 768, 823, 1, 0, -1, -1, 0);
    scan(0, "L4", 4, 0, 55, 768, 823, 0, 0, -1, -1, 0);
    scan(0, "L6", 6, 0, 112, -1, -1, 0, 0, -1, -1, 0);
    scan(0, "L20", 20, 0, 112, -1, -1, 0, 0, -1, -1, 0);
    d_pix = 6'd50;
    scan(0, "L23 pix50", 23, 0, 112, -1, -1, 0, 0, 250, 1495, pe_hi);
    d_pix = 6'd5;
    scan(0, "L24 pix5", 24, 0, 112, -1, -1, 0, 0, 250, 1495, pe_lo);

    // Alternating ce across the hsync trailing edge of line 25
    advance(0, 25, 100, "hold");
    bad_hold = 0;
    for (int i = 0; i < 80; i++) begin
      d_ce = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(0);
      low = (ph[0] < 113);
      if (d_sync_n !== !low) bad_hold++;
      if (int'(d_cvbs) != (low ? 0 : 12)) bad_hold++;
      if (int'(d_hpos) != mh[0] || int'(d_line) != 25) bad_hold++;
    end
    check("hold bad samples", bad_hold, 0);
    check("hold end hpos", int'(d_hpos), 140);
    d_ce = 1'b1;

    // Mid-line reset
    advance(0, 25, 700, "mrst");
    d_reset = 1'b1;
    step(0);
    d_reset = 1'b0;
    check("mrst hpos", int'(d_hpos), 0);
    check("mrst line", int'(d_line), 1);
    check("mrst cvbs", int'(d_cvbs), 0);
    check("mrst sync_n", int'(d_sync_n), 0);
    check("mrst pix_req", int'(d_pix_req), 0);
    step(0);
    check("mrst+1 hpos", int'(d_hpos), 1);
    check("mrst+1 vsync", int'(d_vsync), 1);
    check("mrst+1 sync_n", int'(d_sync_n), 0);
  endtask

  task automatic small_flow();
    s_reset = 1'b1; s_ce = 1'b1; s_pix = 6'd20;
    repeat (2) step(1);
    s_reset = 1'b0;

    advance(1, 312, 63, "s312");
    check("s312 field", int'(s_field), 0);
    step(1);
    check("s313 line", int'(s_line), 313);
    check("s313 field", int'(s_field), 1);
    scan(1, "sL313", 313, 0, 1, 32, 58, 0, 1, -1, -1, 0);
    scan(1, "sL318", 318, 0, 1, -1, -1, 0, 0, -1, -1, 0);
    scan(1, "sL336", 336, 0, 4, -1, -1, 0, 0, 11, 61, 20);

    advance(1, 625, 63, "s625");
    check("s625 field", int'(s_field), 1);
    step(1);
    check("wrap line", int'(s_line), 1);
    check("wrap hpos", int'(s_hpos), 0);
    check("wrap field", int'(s_field), 0);
    check("frame ce count", ns[1], 625 * 64);
  endtask

  initial begin
    fork
      default_flow();
      small_flow();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
